// File: rtl/rx_bit_sampler.sv
// UART RX front end: line synchronizer, oversampling edge/bit counters,
// three-sample mid-bit majority vote and start-edge detection.
module rx_bit_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [5:0] prescale,
  input  logic       rx_in,
  output logic [5:0] edge_count,
  output logic [3:0] bit_count,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       start_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   rx_prev;
  logic                   s0;
  logic                   s1;
  logic [5:0]             half;
  logic [5:0]             last_edge;
  logic                   edge_wrap;
  logic                   bit_wrap;
  logic                   majority;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_prev    <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      rx_prev    <= rx_sync;
      start_edge <= rx_prev & ~rx_sync;
    end
  end

  assign half      = prescale >> 1;
  assign last_edge = prescale - 6'd1;
  // >= so a shrinking prescale mid-bit wraps at once instead of running to 63
  assign edge_wrap = edge_count >= last_edge;
  assign bit_wrap  = bit_count >= 4'(FRAME_BITS - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_wrap) begin
      edge_count <= '0;
      bit_count  <= bit_wrap ? 4'd0 : bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  assign majority = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
    end else if (enable) begin
      if (edge_count == half - 6'd1) s0 <= rx_sync;
      if (edge_count == half) s1 <= rx_sync;
      if (edge_count == half + 6'd1) sampled_bit <= majority;
    end
  end

  assign sample_valid = enable & (edge_count == half + 6'd2);

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
UART RX front end that sits directly upstream of the RX deserializer. It synchronizes the serial line and runs the oversampling edge and bit counters. It takes a 3-sample majority vote near the middle of each bit and presents sampled_bit and edge_count to the deserializer, which captures at edge_count == (prescale>>1)+2. It also flags line falling edges to the RX FSM for start detection.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_in synchronizer (legal values 2..3).
FRAME_BITS, 11, bit-counter modulus: start + 8 data + parity + stop.

Ports:
clk  input  1  system clock (oversampling clock)
rstn  input  1  asynchronous active-low reset
enable  input  1  from the RX FSM; counters run while high
prescale  input  6  oversampling ratio; legal values 8, 16, 32
rx_in  input  1  raw asynchronous serial line, idle high
edge_count  output  6  oversampling edge index within the current bit, 0..prescale-1
bit_count  output  4  bit index within the frame, 0..FRAME_BITS-1
sampled_bit  output  1  majority-voted value of the current bit
sample_valid  output  1  one-cycle pulse: sampled_bit is valid for this bit
start_edge  output  1  one-cycle pulse on a synchronized 1->0 line transition

Behaviour:
- Reset (async, rstn low): all synchronizer flops = 1, rx_prev = 1, edge_count = 0, bit_count = 0, sampled_bit = 1, sample_valid = 0, start_edge = 0, vote registers s0/s1 = 1.
- Synchronizer: rx_sync = rx_in delayed by SYNC_STAGES clocks. All downstream logic uses only rx_sync.
- start_edge: registered; high for exactly one cycle after the clock where rx_prev = 1 and rx_sync = 0. Independent of enable.
- Let half = prescale >> 1, a 6-bit logical shift. All comparisons use the live prescale value.
- enable low: edge_count and bit_count are cleared to 0 synchronously. sample_valid = 0. sampled_bit, s0 and s1 hold their values.
- enable high, edge counter: increments by 1 each clock. At edge_count >= prescale-1 it wraps to 0. The >= compare makes a mid-bit prescale decrease recover within one clock.
- Bit counter: increments on each edge-counter wrap. After FRAME_BITS-1 it wraps to 0 on the next edge wrap.
- Voting (enable high):
  - at edge_count == half-1: s0 <= rx_sync
  - at edge_count == half: s1 <= rx_sync
  - at edge_count == half+1: sampled_bit <= majority(s0, s1, rx_sync)
- sample_valid is high for the single cycle where edge_count == half+2 and enable is high. sampled_bit is stable from then until the next bit's half+1 update.
- This gives the deserializer a value that is settled at its capture edge.
- Latency:
  - line to rx_sync: SYNC_STAGES clocks
  - third vote sample to sampled_bit: 1 clock
  - sampled_bit to sample_valid: same cycle
- Simultaneous events:
  - If enable drops on the same clock as a vote edge, the enable-low rules win and no vote register updates.
  - If enable rises, counting starts from edge_count = 0 on the next clock.
- rstn asserted mid-frame: immediate return to reset values. No partial vote survives.
- Illegal prescale values (< 4 or odd) are not supported and outputs are undefined. The counters must still never exceed 63 or lock up.

Test Plan:
- Reset check: hold rstn low with rx_in toggling -> sampled_bit = 1, edge_count = 0, bit_count = 0, sample_valid = 0, start_edge = 0.
- Start-edge detection: rx_in 1->0 with enable low, SYNC_STAGES = 2 -> start_edge pulses for one cycle, 3 clocks after the line change.
- Steady bit at prescale = 8:
  - Stimulus: enable high, rx_sync held 0.
  - Required: s0/s1 written at edge_count 3/4; sampled_bit = 0 after edge 5; sample_valid high only at edge_count = 6.
  - Required: edge_count wraps 7->0 and bit_count goes 0->1.
- Glitch rejection, prescale = 16:
  - Stimulus: rx_sync = 1 at all three vote edges except a single-cycle 0 at edge_count 8.
  - Required: sampled_bit = 1.
  - Stimulus: 0 at edges 7 and 9.
  - Required: sampled_bit = 0.
- Frame wrap at prescale = 8: 11 full bits (88 clocks) with enable high -> bit_count steps 0..10 and then returns to 0. sample_valid pulses 11 times.
- Enable drop and prescale change:
  - Stimulus: drop enable at edge_count 5, then re-enable.
  - Required: counters clear, no vote occurs, and sampled_bit holds its old value.
  - Stimulus: change prescale 32->8 at edge_count 20.
  - Required: edge_count wraps to 0 on the next clock.
